// File: rtl/la132_dsram_ctrl.sv
// la132_dsram_ctrl: memory-side controller for the la132 data SRAM port.
// Decodes an address window, drives a single-port synchronous RAM and adds
// programmable read wait states. Out-of-window accesses and disallowed fetch
// reads complete with resp=1.
// Optional build macro: DSRAM_PARITY_EN adds per-byte even parity storage
// (mem_par_wdata / mem_par_rdata) and reports read parity errors via resp.
//
// Handshake: a request is presented by holding data_sram_en with stable
// address/data until data_sram_ack is seen (ack only in IDLE). Reads and
// error accesses complete with a single-cycle data_sram_rrdy pulse; hit writes
// complete in the accept cycle with no rrdy.
module la132_dsram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_8000,
  parameter int          MEM_AW      = 13,
  parameter int          WAIT_CYCLES = 1,
  parameter int          FETCH_ALLOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_strb,
  input  logic              data_sram_wr,
  input  logic              data_sram_fetch,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              data_sram_ack,
  output logic              data_sram_rrdy,
  output logic              data_sram_resp,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef DSRAM_PARITY_EN
  ,
  output logic [3:0]        mem_par_wdata,
  input  logic [3:0]        mem_par_rdata
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic       FETCH_OK  = (FETCH_ALLOW != 0);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_dec;
  logic [31:0] rdata_q;
  logic        err_q;    // bus error: response carries resp=1 and zero data
  logic        perr_q;   // parity error captured during a waited read
  logic        pass_q;   // zero-wait read: data comes straight from the RAM
  logic        cap_q;    // first WAIT cycle: RAM output is valid now

  logic accept;
  logic hit;
  logic err;
  logic ram_go;
  logic par_bad;

  // Request decode for the accept cycle.
  always_comb begin
    accept  = data_sram_en & (state == ST_IDLE) & ~reset;
    hit     = (data_sram_addr & ADDR_MASK) == ADDR_BASE;
    err     = ~hit | (data_sram_fetch & ~data_sram_wr & ~FETCH_OK);
    ram_go  = accept & ~err;
    cnt_dec = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  end

`ifdef DSRAM_PARITY_EN
  // Even parity per byte: generated for written bytes, checked on read data.
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_par_wdata[i] = data_sram_strb[i] & (^data_sram_wdata[8*i +: 8]);
      par_bad = par_bad | ((^mem_rdata[8*i +: 8]) ^ mem_par_rdata[i]);
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // RAM side is driven directly from the request in the accept cycle.
  always_comb begin
    mem_cs    = ram_go;
    mem_we    = (ram_go & data_sram_wr) ? data_sram_strb : 4'b0000;
    mem_addr  = data_sram_addr[MEM_AW+1:2];
    mem_wdata = data_sram_wdata;
  end

  // Control FSM: IDLE accepts, WAIT counts read wait states, RESP pulses rrdy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (err) begin
              state  <= ST_RESP;
              err_q  <= 1'b1;
              perr_q <= 1'b0;
              pass_q <= 1'b0;
            end else if (!data_sram_wr) begin
              err_q  <= 1'b0;
              perr_q <= 1'b0;
              if (WAIT_CYCLES == 0) begin
                state  <= ST_RESP;
                pass_q <= 1'b1;
              end else begin
                state  <= ST_WAIT;
                cnt    <= WAIT_INIT;
                cap_q  <= 1'b1;
                pass_q <= 1'b0;
              end
            end
          end
        end
        ST_WAIT: begin
          cap_q <= 1'b0;
          if (cap_q) begin
            rdata_q <= mem_rdata;
            perr_q  <= par_bad;
          end
          cnt <= cnt_dec;
          if (cnt_dec == 4'd0) state <= ST_RESP;
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          err_q  <= 1'b0;
          perr_q <= 1'b0;
          pass_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // CPU-side responses; everything is held low while reset is asserted.
  always_comb begin
    data_sram_ack   = accept;
    data_sram_rrdy  = (state == ST_RESP) & ~reset;
    data_sram_resp  = data_sram_rrdy & (err_q | perr_q | (pass_q & par_bad));
    data_sram_rdata = 32'd0;
    if (data_sram_rrdy && !err_q) data_sram_rdata = pass_q ? mem_rdata : rdata_q;
  end

endmodule

// File: tb/tb_la132_dsram_ctrl.sv
// Bench for la132_dsram_ctrl. Three instances: u0 default (1 wait state,
// fetch allowed), u1 zero wait states with fetch disallowed, u2 four wait
// states. Each has its own behavioural RAM; request fields are shared and
// each instance has its own en bit.
module tb_la132_dsram_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  en;
  logic [3:0]  strb;
  logic        wr;
  logic        fetch;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata [3];
  logic [2:0]  ack, rrdy, resp, cs;
  logic [3:0]  we [3];
  logic [12:0] ma [3];
  logic [31:0] mwd [3];
  logic [31:0] mrd [3];
  logic [3:0]  pw [3];
  logic [3:0]  pr [3];
  logic [3:0]  pflip [3];

  int n_cmp;
  int n_err;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  la132_dsram_ctrl u0 (
    .clk(clk), .reset(reset), .data_sram_en(en[0]), .data_sram_strb(strb),
    .data_sram_wr(wr), .data_sram_fetch(fetch), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[0]), .data_sram_ack(ack[0]),
    .data_sram_rrdy(rrdy[0]), .data_sram_resp(resp[0]), .mem_cs(cs[0]),
    .mem_we(we[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
`ifdef DSRAM_PARITY_EN
    , .mem_par_wdata(pw[0]), .mem_par_rdata(pr[0])
`endif
  );

  la132_dsram_ctrl #(.WAIT_CYCLES(0), .FETCH_ALLOW(0)) u1 (
    .clk(clk), .reset(reset), .data_sram_en(en[1]), .data_sram_strb(strb),
    .data_sram_wr(wr), .data_sram_fetch(fetch), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[1]), .data_sram_ack(ack[1]),
    .data_sram_rrdy(rrdy[1]), .data_sram_resp(resp[1]), .mem_cs(cs[1]),
    .mem_we(we[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
`ifdef DSRAM_PARITY_EN
    , .mem_par_wdata(pw[1]), .mem_par_rdata(pr[1])
`endif
  );

  la132_dsram_ctrl #(.WAIT_CYCLES(4)) u2 (
    .clk(clk), .reset(reset), .data_sram_en(en[2]), .data_sram_strb(strb),
    .data_sram_wr(wr), .data_sram_fetch(fetch), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[2]), .data_sram_ack(ack[2]),
    .data_sram_rrdy(rrdy[2]), .data_sram_resp(resp[2]), .mem_cs(cs[2]),
    .mem_we(we[2]), .mem_addr(ma[2]), .mem_wdata(mwd[2]), .mem_rdata(mrd[2])
`ifdef DSRAM_PARITY_EN
    , .mem_par_wdata(pw[2]), .mem_par_rdata(pr[2])
`endif
  );

  // Behavioural synchronous RAM per instance: read data appears the cycle
  // after a chip select with no byte enables.
  for (genvar g = 0; g < 3; g++) begin : g_ram
    logic [31:0] mem  [8192];
    logic [3:0]  pmem [8192];
    always @(posedge clk) begin
      if (cs[g]) begin
        if (we[g] == 4'b0000) begin
          mrd[g] <= mem[ma[g]];
          pr[g]  <= pmem[ma[g]] ^ pflip[g];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (we[g][b]) begin
              mem[ma[g]][8*b +: 8] = mwd[g][8*b +: 8];
              pmem[ma[g]][b]       = pw[g][b];
            end
          end
        end
      end
    end
  end

  // Driver: advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 3'b111; wr = 1'b0; fetch = 1'b0;
    addr = 32'h1000_0010; strb = 4'hF; wdata = 32'h0;
    step();
    @(negedge clk);
    n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL reset_ack got %b exp 000", ack); end
    n_cmp++; if (rrdy !== 3'b000) begin n_err++; $display("FAIL reset_rrdy got %b exp 000", rrdy); end
    n_cmp++; if (cs !== 3'b000) begin n_err++; $display("FAIL reset_cs got %b exp 000", cs); end
    n_cmp++; if (resp !== 3'b000) begin n_err++; $display("FAIL reset_resp got %b exp 000", resp); end
    n_cmp++; if ((we[0] | we[1] | we[2]) !== 4'h0) begin n_err++; $display("FAIL reset_we got %h exp 0", we[0] | we[1] | we[2]); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rdata[0]); end
    en = 3'b000;
    step();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    step();
    en = 3'b001; wr = 1'b1; addr = 32'h1000_0010; wdata = 32'hDEADBEEF; strb = 4'hF;
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL wr_ack got %b exp 1", ack[0]); end
    n_cmp++; if (cs[0] !== 1'b1 || we[0] !== 4'hF) begin n_err++; $display("FAIL wr_mem cs=%b we=%h exp cs=1 we=f", cs[0], we[0]); end
    n_cmp++; if (ma[0] !== 13'h4 || mwd[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_addr addr=%h data=%h exp 4/deadbeef", ma[0], mwd[0]); end
    n_cmp++; if (rrdy[0] !== 1'b0) begin n_err++; $display("FAIL wr_rrdy_t got %b exp 0", rrdy[0]); end
    step();
    en = 3'b000;
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b0) begin n_err++; $display("FAIL wr_rrdy_t1 got %b exp 0", rrdy[0]); end
    step();
    en = 3'b001; wr = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b1 || cs[0] !== 1'b1 || we[0] !== 4'h0) begin n_err++; $display("FAIL rd_accept ack=%b cs=%b we=%h exp 1/1/0", ack[0], cs[0], we[0]); end
    step();
    en = 3'b000;
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b0) begin n_err++; $display("FAIL rd_rrdy_t1 got %b exp 0", rrdy[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b1 || resp[0] !== 1'b0) begin n_err++; $display("FAIL rd_rrdy_t2 rrdy=%b resp=%b exp 1/0", rrdy[0], resp[0]); end
    n_cmp++; if (rdata[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %h exp deadbeef", rdata[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b0 || rdata[0] !== 32'h0) begin n_err++; $display("FAIL rd_after rrdy=%b rdata=%h exp 0/0", rrdy[0], rdata[0]); end
  endtask

  task automatic test_byte_write();
    step();
    en = 3'b001; wr = 1'b1; addr = 32'h1000_0020; wdata = 32'h11223344; strb = 4'hF;
    step();
    wdata = 32'h000000AA; strb = 4'b0001;
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ack got %b exp 1", ack[0]); end
    n_cmp++; if (we[0] !== 4'b0001) begin n_err++; $display("FAIL byte_we got %b exp 0001", we[0]); end
    step();
    wr = 1'b0; strb = 4'h0;
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL byte_rd_ack got %b exp 1", ack[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b0) begin n_err++; $display("FAIL busy_ack_wait got %b exp 0", ack[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b0 || rrdy[0] !== 1'b1) begin n_err++; $display("FAIL busy_ack_resp ack=%b rrdy=%b exp 0/1", ack[0], rrdy[0]); end
    n_cmp++; if (rdata[0] !== 32'h112233AA) begin n_err++; $display("FAIL byte_rdata got %h exp 112233aa", rdata[0]); end
    step();
    en = 3'b000;
  endtask

  task automatic test_out_of_window();
    step();
    en = 3'b001; wr = 1'b0; addr = 32'h2000_0000;
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b1 || cs[0] !== 1'b0) begin n_err++; $display("FAIL oow_accept ack=%b cs=%b exp 1/0", ack[0], cs[0]); end
    step();
    en = 3'b000;
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b1 || resp[0] !== 1'b1 || rdata[0] !== 32'h0 || cs[0] !== 1'b0) begin
      n_err++; $display("FAIL oow_resp rrdy=%b resp=%b rdata=%h cs=%b exp 1/1/0/0", rrdy[0], resp[0], rdata[0], cs[0]);
    end
    step();
    en = 3'b001; wr = 1'b1; addr = 32'h0000_0000; strb = 4'hF; wdata = 32'h1;
    @(negedge clk);
    n_cmp++; if (ack[0] !== 1'b1 || cs[0] !== 1'b0 || we[0] !== 4'h0) begin n_err++; $display("FAIL oow_wr ack=%b cs=%b we=%h exp 1/0/0", ack[0], cs[0], we[0]); end
    step();
    en = 3'b000;
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b1 || resp[0] !== 1'b1) begin n_err++; $display("FAIL oow_wr_resp rrdy=%b resp=%b exp 1/1", rrdy[0], resp[0]); end
    step();
  endtask

  task automatic test_fetch();
    step();
    en = 3'b010; wr = 1'b1; fetch = 1'b0; addr = 32'h1000_0040; wdata = 32'hCAFEF00D; strb = 4'hF;
    step();
    wr = 1'b0; fetch = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack[1] !== 1'b1 || cs[1] !== 1'b0) begin n_err++; $display("FAIL fetch_accept ack=%b cs=%b exp 1/0", ack[1], cs[1]); end
    step();
    en = 3'b000; fetch = 1'b0;
    @(negedge clk);
    n_cmp++; if (rrdy[1] !== 1'b1 || resp[1] !== 1'b1 || rdata[1] !== 32'h0) begin
      n_err++; $display("FAIL fetch_resp rrdy=%b resp=%b rdata=%h exp 1/1/0", rrdy[1], resp[1], rdata[1]);
    end
    step();
    en = 3'b010;
    @(negedge clk);
    n_cmp++; if (ack[1] !== 1'b1 || cs[1] !== 1'b1) begin n_err++; $display("FAIL nofetch_accept ack=%b cs=%b exp 1/1", ack[1], cs[1]); end
    step();
    en = 3'b000;
    @(negedge clk);
    n_cmp++; if (rrdy[1] !== 1'b1 || resp[1] !== 1'b0 || rdata[1] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL nofetch_resp rrdy=%b resp=%b rdata=%h exp 1/0/cafef00d", rrdy[1], resp[1], rdata[1]);
    end
    step();
  endtask

  task automatic test_reset_wait();
    int seen;
    int lat;
    logic [31:0] got;
    seen = 0; lat = 0; got = 32'h0;
    step();
    en = 3'b100; wr = 1'b1; addr = 32'h1000_0080; wdata = 32'h5A5A1234; strb = 4'hF;
    step();
    wr = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack[2] !== 1'b1) begin n_err++; $display("FAIL w4_ack got %b exp 1", ack[2]); end
    step();
    en = 3'b000;
    step();
    reset = 1'b1; en = 3'b100;
    @(negedge clk);
    n_cmp++; if (ack[2] !== 1'b0 || rrdy[2] !== 1'b0) begin n_err++; $display("FAIL w4_rst_out ack=%b rrdy=%b exp 0/0", ack[2], rrdy[2]); end
    step();
    reset = 1'b0; en = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rrdy[2]) seen++;
      step();
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL w4_dropped rrdy_count=%0d exp 0", seen); end
    en = 3'b100;
    @(negedge clk);
    n_cmp++; if (ack[2] !== 1'b1) begin n_err++; $display("FAIL w4_reack got %b exp 1", ack[2]); end
    for (int i = 1; i <= 20; i++) begin
      step();
      en = 3'b000;
      @(negedge clk);
      if (rrdy[2]) begin
        lat = i; got = rdata[2];
        break;
      end
    end
    n_cmp++; if (lat != 5) begin n_err++; $display("FAIL w4_latency got %0d exp 5", lat); end
    n_cmp++; if (got !== 32'h5A5A1234) begin n_err++; $display("FAIL w4_rdata got %h exp 5a5a1234", got); end
    step();
  endtask

`ifdef DSRAM_PARITY_EN
  task automatic test_parity();
    step();
    pflip[0] = 4'b0100;
    en = 3'b001; wr = 1'b0; addr = 32'h1000_0010;
    step();
    en = 3'b000;
    step();
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b1 || resp[0] !== 1'b1) begin n_err++; $display("FAIL par_err rrdy=%b resp=%b exp 1/1", rrdy[0], resp[0]); end
    n_cmp++; if (rdata[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL par_rdata got %h exp deadbeef", rdata[0]); end
    step();
    pflip[0] = 4'b0000;
    en = 3'b001;
    step();
    en = 3'b000;
    step();
    @(negedge clk);
    n_cmp++; if (rrdy[0] !== 1'b1 || resp[0] !== 1'b0) begin n_err++; $display("FAIL par_ok rrdy=%b resp=%b exp 1/0", rrdy[0], resp[0]); end
    step();
  endtask
`endif

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; en = 3'b000; strb = 4'h0; wr = 1'b0; fetch = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      pflip[k] = 4'b0000;
`ifndef DSRAM_PARITY_EN
      pw[k] = 4'b0000;
`endif
    end
    test_reset();
    test_write_read();
    test_byte_write();
    test_out_of_window();
    test_fetch();
    test_reset_wait();
`ifdef DSRAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/la132_dsram_ctrl.md
Name: la132_dsram_ctrl

Overview:
- Memory-side controller for the la132 core's data SRAM port. Downstream of the CPU: it consumes data_sram_en/strb/wr/fetch/addr/wdata and answers with data_sram_ack/rrdy/resp/rdata.
- Decodes an address window, drives a single-port synchronous on-chip RAM, and inserts programmable read wait states.
- Reports out-of-window and disallowed-fetch accesses as bus errors via resp.

Parameters:
- ADDR_BASE, 32'h1000_0000, window base; hit when (addr & ADDR_MASK) == ADDR_BASE.
- ADDR_MASK, 32'hFFFF_8000, window mask (default gives a 32 KB window).
- MEM_AW, 13, RAM word-address width; mem_addr = addr[MEM_AW+1:2].
- WAIT_CYCLES, 1, extra read wait states, range 0..15.
- FETCH_ALLOW, 1, 1 = fetch accesses permitted; 0 = fetch returns an error.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- data_sram_en  in  1  request valid
- data_sram_strb  in  4  byte enables (writes)
- data_sram_wr  in  1  1 = write, 0 = read
- data_sram_fetch  in  1  instruction-fetch qualifier
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid when rrdy=1
- data_sram_ack  out  1  request accepted this cycle
- data_sram_rrdy  out  1  one-cycle completion pulse
- data_sram_resp  out  1  error flag, qualified by rrdy
- mem_cs  out  1  RAM chip select
- mem_we  out  4  RAM byte write enables
- mem_addr  out  MEM_AW  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_cs with mem_we=0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- States: IDLE, WAIT, RESP. On reset: state=IDLE, wait counter=0, rdata register=0.
- Outputs forced low while reset=1: ack, rrdy, resp, mem_cs, mem_we.
- ack = en & (state==IDLE) & ~reset, combinational. No request is accepted outside IDLE; the CPU holds en until it sees ack.
- Accept in cycle T:
  - hit = (addr & ADDR_MASK) == ADDR_BASE.
  - err = ~hit | (fetch & ~wr & ~FETCH_ALLOW).
- Write hit: mem_cs=1 and mem_we=strb in cycle T. Stay in IDLE; no rrdy. Back-to-back writes are accepted every cycle.
- strb=0 write hit: mem_cs=1, mem_we=0. The RAM read result is discarded.
- Read hit: mem_cs=1, mem_we=0 in cycle T.
  - If WAIT_CYCLES=0, go to RESP. At T+1: rrdy=1, resp=0, rdata=mem_rdata (pass-through).
  - If WAIT_CYCLES>0, go to WAIT and load counter=WAIT_CYCLES. At T+1, capture mem_rdata into the register. Decrement the counter each cycle; at 0 go to RESP.
  - rrdy=1 at T+1+WAIT_CYCLES, with rdata taken from the register.
- Any err access (read or write): no RAM access. Go to RESP; at T+1, rrdy=1, resp=1, rdata=0.
- RESP lasts exactly one cycle, then IDLE. The next accept is possible in the cycle after the rrdy cycle.
- rdata is 0 whenever rrdy=0.
- mem_addr and mem_wdata are driven from the request inputs in the accept cycle; they are don't-care otherwise.
- Reset mid-read: the pending response is dropped, with no rrdy after reset deasserts, and state returns to IDLE.
- Counter is 4 bits and saturates at 0; it never wraps.

Optional Feature:
- DSRAM_PARITY_EN.
- Defined:
  - Adds ports mem_par_wdata out 4 and mem_par_rdata in 4.
  - Writes store even parity per byte (^wdata[8i+7:8i]) for the written bytes only.
  - On a read hit, the parity of mem_rdata is checked against mem_par_rdata at T+1. Any mismatch sets resp=1 in the rrdy cycle; rdata is still returned.
- Undefined: no parity ports or logic; read-hit resp is always 0.

Test Plan:
- Read hit, WAIT_CYCLES=1: write 0xDEADBEEF to 0x1000_0010 with strb=4'hF, then read the same address.
  - Write: ack in the accept cycle, no rrdy.
  - Read: rrdy exactly 2 cycles after ack, rdata=0xDEADBEEF, resp=0.
- Byte write: preload 0x1000_0020 with 0x11223344, then write 0x000000AA with strb=4'b0001.
  - mem_we=4'b0001. A subsequent read returns 0x112233AA.
- Out-of-window read to 0x2000_0000:
  - ack at T, rrdy at T+1 with resp=1 and rdata=0, mem_cs never asserted.
- FETCH_ALLOW=0 with fetch=1 read to an in-window address:
  - resp=1 at T+1, no RAM access.
  - The same read with fetch=0 succeeds.
- Reset during WAIT (WAIT_CYCLES=4): assert reset 2 cycles after accepting a read.
  - ack/rrdy go 0 immediately, and no rrdy occurs after release.
  - The next read completes normally.
- DSRAM_PARITY_EN: force mem_par_rdata[2] flipped on a read hit.
  - rrdy with resp=1; rdata equals the stored value.
